// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug clock-monitor gate controller.
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_GATE  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int W_CNT_DEF = 16;

  // Saturation threshold 2^w - 2: the monitor can overshoot one past its
  // nominal limit, so anything at or above this is treated as saturated.
  function automatic logic [63:0] sat_thr(input int w);
    return (64'd1 << w) - 64'd2;
  endfunction

endpackage

// File: rtl/dbg_gate_timer.sv
// Gate-window down-counter: loads the window length, counts down while
// enabled and flags the last cycle of the window.
module dbg_gate_timer #(
  parameter int W_GATE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [W_GATE-1:0] length,
  input  logic              enable,
  output logic              last
);

  logic [W_GATE-1:0] cnt_q, cnt_d;

  // A zero-length window would never reach 1, so treat it as one cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = (length == '0) ? W_GATE'(1) : length;
    else if (enable && (cnt_q != '0))
      cnt_d = cnt_q - W_GATE'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = enable && (cnt_q == W_GATE'(1));

endmodule

// File: rtl/dbg_clkmon_gate.sv
// Gate controller and readout sequencer for the debug clock monitor:
// clears the monitor, times the window, snapshots counts onto a valid/ready port.
module dbg_clkmon_gate
  import dbg_pkg::*;
#(
  parameter int W_CNT  = W_CNT_DEF,
  parameter int W_GATE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic [W_GATE-1:0]  gate_len,
  output logic               mon_rst,
  input  logic [2*W_CNT-1:0] mon_cnt,
  output logic [W_CNT-1:0]   res_syn,
  output logic [W_CNT-1:0]   res_pdc,
  output logic [1:0]         res_sat,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               ovr
);

  localparam logic [W_CNT-1:0] SAT_THR = W_CNT'(sat_thr(W_CNT));

  state_e            state_q, state_d;
  logic [W_GATE-1:0] len_q, len_d;
  logic              mon_rst_q, mon_rst_d;
  logic [W_CNT-1:0]  syn_q, syn_d, pdc_q, pdc_d;
  logic [1:0]        sat_q, sat_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              last, capture, xfer, accept;
  logic [W_CNT-1:0]  fld_syn, fld_pdc;

  assign fld_syn = mon_cnt[2*W_CNT-1:W_CNT];
  assign fld_pdc = mon_cnt[W_CNT-1:0];

  dbg_gate_timer #(.W_GATE(W_GATE)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state_q == ST_CLEAR),
    .length (len_q),
    .enable (state_q == ST_GATE),
    .last   (last)
  );

  assign accept  = (state_q == ST_IDLE) && start;
  assign capture = (state_q == ST_GATE) && last;
  assign xfer    = valid_q && res_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_CLEAR;
        len_d   = gate_len;
      end
      ST_CLEAR: state_d = ST_GATE;
      ST_GATE:  if (last) state_d = cont ? ST_CLEAR : ST_HOLD;
      ST_HOLD:  if (xfer) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Registered so the monitor clear is glitch-free and aligned to CLEAR.
    mon_rst_d = (state_d == ST_CLEAR);
  end

  always_comb begin
    syn_d   = syn_q;
    pdc_d   = pdc_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (accept) ovr_d = 1'b0;
    if (capture) begin
      syn_d   = fld_syn;
      pdc_d   = fld_pdc;
      sat_d   = {fld_syn >= SAT_THR, fld_pdc >= SAT_THR};
      valid_d = 1'b1;
      // A result being taken this same cycle is not lost, so no overrun.
      if (valid_q && !res_ready) ovr_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      mon_rst_q <= 1'b1;
      syn_q     <= '0;
      pdc_q     <= '0;
      sat_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      mon_rst_q <= mon_rst_d;
      syn_q     <= syn_d;
      pdc_q     <= pdc_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign mon_rst   = mon_rst_q;
  assign res_syn   = syn_q;
  assign res_pdc   = pdc_q;
  assign res_sat   = sat_q;
  assign res_valid = valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_dbg_clkmon_gate.sv
// Directed bench for dbg_clkmon_gate with a behavioural stand-in for the
// clock monitor (2-stage input pipeline, saturating counters, running-total view).
module tb_dbg_clkmon_gate;

  logic        clk = 1'b0;
  logic        rst, start, cont, res_ready;
  logic [15:0] gate_len;
  logic        mon_rst, res_valid, busy, ovr;
  logic [31:0] mon_cnt;
  logic [15:0] res_syn, res_pdc;
  logic [1:0]  res_sat;

  logic        start4, ready4, mon_rst4, valid4, busy4, ovr4;
  logic [7:0]  mon_cnt4;
  logic [3:0]  syn4, pdc4;
  logic [1:0]  sat4;

  always #5 clk = ~clk;

  dbg_clkmon_gate #(.W_CNT(16), .W_GATE(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .gate_len(gate_len),
    .mon_rst(mon_rst), .mon_cnt(mon_cnt), .res_syn(res_syn), .res_pdc(res_pdc),
    .res_sat(res_sat), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .ovr(ovr)
  );

  dbg_clkmon_gate #(.W_CNT(4), .W_GATE(16)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .cont(1'b0), .gate_len(16'd20),
    .mon_rst(mon_rst4), .mon_cnt(mon_cnt4), .res_syn(syn4), .res_pdc(pdc4),
    .res_sat(sat4), .res_valid(valid4), .res_ready(ready4),
    .busy(busy4), .ovr(ovr4)
  );

  // Monitor model. Input mode: 0 = low, 1 = high, 2 = toggle every cycle.
  logic [1:0]  syn_mode, pdc_mode;
  logic        force_en;
  logic [31:0] force_val;
  logic        tog_q = 1'b0, p1s = 1'b0, p2s = 1'b0, p1p = 1'b0, p2p = 1'b0;
  logic        in_syn, in_pdc;
  logic [15:0] cs_q = '0, cp_q = '0, cs_v, cp_v;
  logic [3:0]  c4_q = '0, c4_v;

  function automatic logic [15:0] sinc(input logic [15:0] c, input logic b);
    return (b && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  assign in_syn   = (syn_mode == 2'd2) ? tog_q : syn_mode[0];
  assign in_pdc   = (pdc_mode == 2'd2) ? tog_q : pdc_mode[0];
  assign cs_v     = sinc(cs_q, p2s);
  assign cp_v     = sinc(cp_q, p2p);
  assign mon_cnt  = force_en ? force_val : {cs_v, cp_v};
  assign c4_v     = (c4_q == 4'hF) ? c4_q : c4_q + 4'd1;
  assign mon_cnt4 = {c4_v, 4'h0};

  always @(posedge clk) begin
    tog_q <= ~tog_q;
    p1s <= in_syn; p2s <= p1s;
    p1p <= in_pdc; p2p <= p1p;
    cs_q <= mon_rst ? 16'd0 : cs_v;
    cp_q <= mon_rst ? 16'd0 : cp_v;
    c4_q <= mon_rst4 ? 4'd0 : c4_v;
  end

  int n_chk = 0, n_fail = 0, n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  typedef struct {
    logic [15:0] gl;
    logic [1:0]  sm, pm;
    logic        fe;
    logic [31:0] fv;
    logic [15:0] es, ep;
    logic [1:0]  esat;
  } vec_t;

  vec_t tbl[7];

  // Single-shot run: start, check CLEAR pulse, latency, data, hold, handshake.
  task automatic run_vec(input vec_t v);
    int leff;
    leff = (v.gl == 16'd0) ? 1 : int'(v.gl);
    @(negedge clk);
    syn_mode = v.sm; pdc_mode = v.pm; force_en = v.fe; force_val = v.fv;
    gate_len = v.gl; cont = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk); n = 1;
    start = 1'b0;
    chk("clear_mon_rst", mon_rst, 1);
    chk("clear_busy", busy, 1);
    step();
    chk("gate_mon_rst", mon_rst, 0);
    while (!res_valid && n < 400) step();
    chk("latency", n, leff + 2);
    chk("res_syn", res_syn, v.es);
    chk("res_pdc", res_pdc, v.ep);
    chk("res_sat", res_sat, v.esat);
    step();
    chk("hold_valid", res_valid, 1);
    chk("hold_syn", res_syn, v.es);
    chk("hold_busy", busy, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("accept_valid", res_valid, 0);
    chk("accept_busy", busy, 0);
  endtask

  initial begin : main
    logic seen;
    tbl[0] = '{16'd100, 2'd1, 2'd0, 1'b0, 32'h0,             16'd100,   16'd0,     2'b00};
    tbl[1] = '{16'd64,  2'd0, 2'd2, 1'b0, 32'h0,             16'd0,     16'd32,    2'b00};
    tbl[2] = '{16'd0,   2'd1, 2'd0, 1'b0, 32'h0,             16'd1,     16'd0,     2'b00};
    tbl[3] = '{16'd5,   2'd1, 2'd1, 1'b0, 32'h0,             16'd5,     16'd5,     2'b00};
    tbl[4] = '{16'd8,   2'd2, 2'd1, 1'b0, 32'h0,             16'd4,     16'd8,     2'b00};
    tbl[5] = '{16'd3,   2'd0, 2'd0, 1'b1, 32'hFFFE_FFFD,     16'hFFFE,  16'hFFFD,  2'b10};
    tbl[6] = '{16'd3,   2'd0, 2'd0, 1'b1, 32'h0001_FFFF,     16'h0001,  16'hFFFF,  2'b01};

    rst = 1'b1; start = 1'b0; cont = 1'b0; res_ready = 1'b0; gate_len = '0;
    start4 = 1'b0; ready4 = 1'b0;
    syn_mode = 2'd0; pdc_mode = 2'd0; force_en = 1'b0; force_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_mon_rst", mon_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_res", {res_syn, res_pdc, res_sat}, 0);
    chk("rst_mon_rst4", mon_rst4, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_mon_rst", mon_rst, 0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Continuous, result never taken: overwrite raises ovr; start ignored; cont dropped.
    force_en = 1'b0; syn_mode = 2'd1; pdc_mode = 2'd0;
    gate_len = 16'd10; cont = 1'b1; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; @(negedge clk); n = 1; start = 1'b0;
    while (n < 11) step();
    chk("c1_early_valid", res_valid, 0);
    step();
    chk("c1_valid", res_valid, 1);
    chk("c1_syn", res_syn, 10);
    chk("c1_ovr", ovr, 0);
    while (n < 22) step();
    chk("c1_pre_ovr", ovr, 0);
    step();
    chk("c1_ovr_set", ovr, 1);
    chk("c1_valid2", res_valid, 1);
    chk("c1_syn2", res_syn, 10);
    start = 1'b1;
    step();
    start = 1'b0; cont = 1'b0;
    chk("c1_start_ignored", {busy, ovr}, 2'b11);
    while (n < 34) step();
    chk("c1_hold", {res_valid, busy, ovr}, 3'b111);
    step();
    chk("c1_hold_busy", busy, 1);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    chk("c1_idle", {res_valid, busy}, 2'b00);

    // Continuous with acceptance coinciding with a capture: no overrun.
    cont = 1'b1;
    @(negedge clk);
    start = 1'b1; @(negedge clk); n = 1; start = 1'b0;
    chk("c2_ovr_cleared", ovr, 0);
    while (n < 22) step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0; cont = 1'b0;
    chk("c2_coincide", {res_valid, ovr}, 2'b10);
    chk("c2_syn", res_syn, 10);
    while (n < 34) step();
    chk("c2_last_ovr", {res_valid, busy, ovr}, 3'b111);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    chk("c2_idle", {res_valid, busy}, 2'b00);

    // Reset in mid-window abandons the measurement.
    gate_len = 16'd50;
    @(negedge clk);
    start = 1'b1; @(negedge clk); n = 1; start = 1'b0;
    while (n < 20) step();
    rst = 1'b1;
    step();
    chk("mid_rst_mon_rst", mon_rst, 1);
    chk("mid_rst_outs", {busy, res_valid, ovr, res_sat, res_syn, res_pdc}, 0);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_release", {mon_rst, busy}, 2'b00);
    seen = 1'b0;
    repeat (70) begin step(); if (res_valid) seen = 1'b1; end
    chk("mid_rst_no_result", seen, 0);
    run_vec(tbl[0]);

    // Narrow monitor: 20-cycle window saturates a 4-bit syn count.
    @(negedge clk);
    start4 = 1'b1; @(negedge clk); n = 1; start4 = 1'b0;
    while (!valid4 && n < 100) step();
    chk("w4_latency", n, 22);
    chk("w4_syn", syn4, 4'd15);
    chk("w4_pdc", pdc4, 4'd0);
    chk("w4_sat", sat4, 2'b10);
    ready4 = 1'b1; step(); ready4 = 1'b0;
    chk("w4_idle", {valid4, busy4}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_clkmon_gate.md
# dbg_clkmon_gate

Gate controller and readout sequencer for the debug clock monitor. It clears the monitor and opens a measurement window of programmable length. At window close it snapshots the monitor's packed `{c_syn, c_pdc}` count word and delivers the two counts, with saturation flags, over a valid/ready result port. It sits between the monitor instance and the debug register/readout logic, and supports single-shot and continuous measurement.

## Interface
- `W_CNT`, default 16: width of each monitor count field. The monitor word is 2*W_CNT bits, with the syn field in the high half.
- `W_GATE`, default 16: width of the gate-length counter.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin measurement. Sampled only in IDLE.
- `cont`, in, 1: continuous mode. Sampled at every capture.
- `gate_len`, in, W_GATE: window length in clk cycles. Latched when `start` is accepted; 0 is coerced to 1.
- `mon_rst`, out, 1: registered clear to the monitor's `rst`.
- `mon_cnt`, in, 2*W_CNT: monitor count word.
- `res_syn`, out, W_CNT: captured syn count.
- `res_pdc`, out, W_CNT: captured pdc count.
- `res_sat`, out, 2: bit 1 is syn saturated, bit 0 is pdc saturated.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: consumer accepts the result.
- `busy`, out, 1: high in any state other than IDLE.
- `ovr`, out, 1: sticky flag; an unconsumed result was overwritten.

## Operation
- **States:** IDLE, CLEAR, GATE, HOLD.
- **IDLE:** `mon_rst` = 0 and the monitor free-runs. `start` = 1 selects CLEAR, latches `gate_len`, and clears `ovr`.
- **CLEAR:** lasts exactly one cycle with `mon_rst` = 1. The gate down-counter loads the latched length. Next state is GATE.
- **GATE:** the counter decrements each cycle. On the cycle it reads 1, the block captures `mon_cnt` into `res_syn`/`res_pdc`, sets `res_valid`, and computes `res_sat[i]` = (field >= 2^W_CNT − 2).
  - The ≥ N_MAX−1 threshold is conservative, because the monitor can overshoot to N_MAX.
- **After capture:** if `cont` = 1, go to CLEAR; otherwise go to HOLD.
- **HOLD:** wait for `res_valid & res_ready`, then go to IDLE.
- **Handshake:** a transfer happens when `res_valid & res_ready`; `res_valid` falls on the next cycle. Result registers are stable while `res_valid` = 1 and not accepted, except in continuous mode.
- **Continuous overwrite:** a capture while the old result is unaccepted overwrites the result registers, keeps `res_valid` = 1, and sets `ovr`.
- **Capture coinciding with acceptance:** the new result loads, `res_valid` stays 1, and `ovr` is not set.
- **`cont` dropped mid-window:** the current window completes, the block goes to HOLD, then to IDLE after acceptance.
- **`start` outside IDLE:** ignored.
- **`rst`:** sets the state to IDLE, `mon_rst` = 1, and `res_syn` = `res_pdc` = `res_sat` = `res_valid` = `busy` = `ovr` = 0.
  - `mon_rst` holds 1 through reset so the monitor stays cleared; it goes to 0 on the first cycle after reset in IDLE.
  - A reset mid-window abandons the measurement with no result.

## Timing
- `start` accepted at edge of cycle T: CLEAR is cycle T+1, with `mon_rst` high only in T+1.
- The monitor fields are 0 in cycle T+2.
- Capture occurs at the end of cycle T+1+L, where L is the effective gate length. `res_valid` is high from cycle T+2+L.
- The count covers L monitor increment cycles. The monitor's 2-cycle input pipeline shifts the sampled window by 2 cycles; the offset is fixed and not compensated.
- **Continuous period:** L+1 cycles per result (CLEAR plus L cycles of GATE), with no dead cycles beyond CLEAR.
- Result and flag outputs are registered; there is no combinational path from `res_ready` to `res_valid`.

## Structure
- Shared package `dbg_pkg`: state enum (IDLE/CLEAR/GATE/HOLD), the default W_CNT, and the saturation-threshold function sat_thr(W) = 2^W − 2.
- One sub-module, `dbg_gate_timer`:
  - Inputs: load, length, enable.
  - Output: `last` pulse on count == 1.
  - Implements the zero-to-one coercion.
- The top level holds the FSM, result registers, and handshake.

## Test plan
Each scenario instantiates the block together with the monitor (W_CNT = 16 unless stated).
1. `in_syn` = 1 constant, `in_pdc` = 0, `gate_len` = 100, single-shot → `res_syn` = 100, `res_pdc` = 0, `res_sat` = 0, `res_valid` at T+102; `busy` falls the cycle after acceptance.
2. `in_pdc` toggling every cycle, `in_syn` = 0, `gate_len` = 64 → `res_pdc` = 32, `res_syn` = 0.
3. W_CNT = 4, `in_syn` = 1, `gate_len` = 20 → `res_syn` = 15, `res_sat` = 2'b10.
4. Continuous mode, `gate_len` = 10, `res_ready` held 0 for 25 cycles → results every 11 cycles, `ovr` = 1 after the 2nd capture, `res_valid` held; then assert `res_ready` coinciding with a capture → no new `ovr` event.
5. `gate_len` = 0 → behaves as 1, with the result valid at T+3.
6. Assert `rst` mid-GATE → no result, `mon_rst` = 1 during reset, outputs zero; a subsequent `start` yields correct counts.
